// File: rtl/branch_predictor.sv
// Table of saturating counters indexed by PC bits; same-cycle taken/not-taken prediction for ID.
// Counters are trained by branch resolution; resolved-branch and mispredict statistics kept for debug.
module branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 1,
  parameter int INIT_CTR   = 1,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic [PC_WIDTH-1:0]   i_lookup_pc,
  input  logic                  i_is_branch,
  output logic                  o_prediction,
  output logic                  o_ready,
  input  logic                  i_update_valid,
  input  logic [PC_WIDTH-1:0]   i_update_pc,
  input  logic                  i_update_taken,
  input  logic                  i_update_mispredict,
  output logic [STAT_WIDTH-1:0] o_branch_count,
  output logic [STAT_WIDTH-1:0] o_mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [INDEX_BITS-1:0] ptr;
  logic [CTR_BITS-1:0]   ctr_table [DEPTH];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [CTR_BITS-1:0]   update_cur;
  logic [CTR_BITS-1:0]   update_ctr;
  logic                  init_last;
  logic                  unused_pc_bits;

  assign lookup_idx = i_lookup_pc[INDEX_BITS+1:2];
  assign update_idx = i_update_pc[INDEX_BITS+1:2];
  assign init_last  = (ptr == INDEX_BITS'(DEPTH - 1));

  // Low byte-offset bits and high bits only alias entries; they take no part in indexing.
  assign unused_pc_bits = ^{i_lookup_pc[1:0], i_lookup_pc[PC_WIDTH-1:INDEX_BITS+2],
                            i_update_pc[1:0], i_update_pc[PC_WIDTH-1:INDEX_BITS+2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = INIT;
    end else begin
      case (state)
        INIT:    if (init_last) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      ptr <= '0;
    end else if (state == INIT) begin
      ptr <= ptr + INDEX_BITS'(1);
    end
  end

  always_comb begin
    update_cur = ctr_table[update_idx];
    update_ctr = update_cur;
    if (i_update_taken) begin
      if (update_cur != '1) update_ctr = update_cur + CTR_BITS'(1);
    end else begin
      if (update_cur != '0) update_ctr = update_cur - CTR_BITS'(1);
    end
  end

  // The table has no reset; the INIT sweep writes every entry before predictions are enabled.
  always_ff @(posedge clk) begin
    if (!reset && !i_flush) begin
      if (state == INIT) begin
        ctr_table[ptr] <= CTR_BITS'(INIT_CTR);
      end else if (i_update_valid) begin
        ctr_table[update_idx] <= update_ctr;
      end
    end
  end

  assign o_ready      = (state == RUN);
  assign o_prediction = i_is_branch & o_ready & (MODE == 1) & ctr_table[lookup_idx][CTR_BITS-1];

  // Statistics survive flushes and count updates even while the table is initialising.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
    end else begin
      if (i_update_valid && (o_branch_count != '1)) begin
        o_branch_count <= o_branch_count + STAT_WIDTH'(1);
      end
      if (i_update_valid && i_update_mispredict && (o_mispredict_count != '1)) begin
        o_mispredict_count <= o_mispredict_count + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor: a dynamic (MODE=1) and a static (MODE=0) instance share stimulus.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_flush;
  logic [31:0] i_lookup_pc;
  logic        i_is_branch;
  logic        i_update_valid;
  logic [31:0] i_update_pc;
  logic        i_update_taken;
  logic        i_update_mispredict;

  logic        dyn_prediction, dyn_ready;
  logic [31:0] dyn_branch_count, dyn_mispredict_count;
  logic        sta_prediction, sta_ready;
  logic [31:0] sta_branch_count, sta_mispredict_count;

  always #5 clk = ~clk;

  branch_predictor #(.MODE(1)) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush),
    .i_lookup_pc(i_lookup_pc), .i_is_branch(i_is_branch),
    .o_prediction(dyn_prediction), .o_ready(dyn_ready),
    .i_update_valid(i_update_valid), .i_update_pc(i_update_pc),
    .i_update_taken(i_update_taken), .i_update_mispredict(i_update_mispredict),
    .o_branch_count(dyn_branch_count), .o_mispredict_count(dyn_mispredict_count)
  );

  branch_predictor #(.MODE(0)) dut_static (
    .clk(clk), .reset(reset), .i_flush(i_flush),
    .i_lookup_pc(i_lookup_pc), .i_is_branch(i_is_branch),
    .o_prediction(sta_prediction), .o_ready(sta_ready),
    .i_update_valid(i_update_valid), .i_update_pc(i_update_pc),
    .i_update_taken(i_update_taken), .i_update_mispredict(i_update_mispredict),
    .o_branch_count(sta_branch_count), .o_mispredict_count(sta_mispredict_count)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model of the dynamic instance.
  bit [1:0] mdl [64];
  bit       m_ready;
  int       m_ptr;
  int       exp_b;
  int       exp_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag  = $sformatf("%s@%0d", tag, cyc);
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = {31'd0, dyn_prediction};
        1:       obs = {31'd0, dyn_ready};
        2:       obs = dyn_branch_count;
        3:       obs = dyn_mispredict_count;
        4:       obs = {31'd0, sta_prediction};
        5:       obs = {31'd0, sta_ready};
        default: obs = 32'hdead_beef;
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic cycle(input bit br, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input bit um, input bit fl);
    bit       mp;
    bit [5:0] li;
    bit [5:0] ui;
    i_is_branch         = br;
    i_lookup_pc         = lpc;
    i_update_valid      = uv;
    i_update_pc         = upc;
    i_update_taken      = ut;
    i_update_mispredict = um;
    i_flush             = fl;
    li = lpc[7:2];
    ui = upc[7:2];
    mp = br && m_ready && mdl[li][1];
    push("pred", 0, {31'd0, mp});
    push("ready", 1, {31'd0, m_ready});
    push("bcnt", 2, exp_b);
    push("mcnt", 3, exp_m);
    push("spred", 4, 32'd0);
    push("sready", 5, {31'd0, m_ready});
    @(negedge clk);
    drain();
    @(posedge clk);
    if (fl) begin
      m_ready = 1'b0;
      m_ptr   = 0;
    end else if (!m_ready) begin
      mdl[m_ptr] = 2'd1;
      if (m_ptr == 63) m_ready = 1'b1;
      else             m_ptr++;
    end else if (uv) begin
      if (ut && mdl[ui] != 2'd3)       mdl[ui] = mdl[ui] + 2'd1;
      else if (!ut && mdl[ui] != 2'd0) mdl[ui] = mdl[ui] - 2'd1;
    end
    if (uv) exp_b++;
    if (uv && um) exp_m++;
    cyc++;
    #1;
  endtask

  task automatic idle(input bit br, input logic [31:0] lpc);
    cycle(br, lpc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] upc, input bit ut, input bit um);
    cycle(1'b0, 32'h0, 1'b1, upc, ut, um, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    i_flush = 1'b0;
    i_is_branch = 1'b1;
    i_lookup_pc = 32'h40;
    i_update_valid = 1'b0;
    i_update_pc = 32'h0;
    i_update_taken = 1'b0;
    i_update_mispredict = 1'b0;
    m_ready = 1'b0;
    m_ptr = 0;
    exp_b = 0;
    exp_m = 0;

    repeat (3) @(posedge clk);
    #1;
    push("rst_ready", 1, 32'd0);
    push("rst_pred", 0, 32'd0);
    push("rst_bcnt", 2, 32'd0);
    push("rst_mcnt", 3, 32'd0);
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First INIT sweep, with updates that must only reach the statistics.
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 32'h80, (i < 3), 32'h80, 1'b1, (i == 0), 1'b0);
    end
    @(negedge clk);
    chk("ready_after_64", {31'd0, dyn_ready}, 32'd1);
    @(posedge clk);
    #1;

    idle(1'b1, 32'h80);
    upd(32'h40, 1'b1, 1'b0);
    upd(32'h40, 1'b1, 1'b1);
    idle(1'b1, 32'h40);
    idle(1'b1, 32'h44);
    idle(1'b1, 32'h140);
    idle(1'b0, 32'h40);

    repeat (3) upd(32'h40, 1'b1, 1'b0);
    cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 32'h40);

    // Same-cycle lookup and update: pre-update value must be seen.
    cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h40);

    cycle(1'b1, 32'h44, 1'b0, 32'h44, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h48, 1'b1, 32'h48, 1'b0, i[0], 1'b0);
    cycle(1'b1, 32'h48, 1'b1, 32'h48, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h48);

    for (int i = 0; i < 40; i++) begin
      cycle($urandom_range(0, 1) == 1, 32'($urandom_range(0, 1023)),
            $urandom_range(0, 3) != 0, 32'($urandom_range(0, 15) << 2),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
    end

    // Flush in RUN, then flush again mid-INIT to restart the sweep.
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h40, (i == 5), 32'h40, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) idle(1'b1, 32'h40);
    @(negedge clk);
    chk("ready_after_flush", {31'd0, dyn_ready}, 32'd1);
    @(posedge clk);
    #1;
    idle(1'b1, 32'h40);
    idle(1'b1, 32'h4c);
    upd(32'h4c, 1'b1, 1'b0);
    idle(1'b1, 32'h4c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
